// File: rtl/if_id_ex_pipe_regs_if.sv
// Bus bundle between the hazard/fetch/decode logic and the IF/ID + ID/EX pipeline registers.
// master drives fetch/decode data and hazard commands; slave is the register bank.
interface if_id_ex_pipe_regs_if #(
  parameter int CTRL_W = 12
);
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic [31:0]       InstrF;
  logic [31:0]       PCF;
  logic [31:0]       PCPlus4F;
  logic [31:0]       RD1D;
  logic [31:0]       RD2D;
  logic [31:0]       ImmExtD;
  logic [CTRL_W-1:0] CtrlD;

  logic [31:0]       InstrD;
  logic [31:0]       PCD;
  logic [31:0]       PCPlus4D;
  logic              ValidD;
  logic [4:0]        Rs1D;
  logic [4:0]        Rs2D;
  logic [4:0]        RdD;
  logic [31:0]       RD1E;
  logic [31:0]       RD2E;
  logic [31:0]       ImmExtE;
  logic [31:0]       PCE;
  logic [31:0]       PCPlus4E;
  logic [4:0]        Rs1E;
  logic [4:0]        Rs2E;
  logic [4:0]        RdE;
  logic [CTRL_W-1:0] CtrlE;
  logic              ValidE;
  logic              StallTimeout;
  logic [31:0]       StallCycles;
  logic [31:0]       FlushCount;

  modport master (
    output StallD, FlushD, FlushE, InstrF, PCF, PCPlus4F, RD1D, RD2D, ImmExtD, CtrlD,
    input  InstrD, PCD, PCPlus4D, ValidD, Rs1D, Rs2D, RdD, RD1E, RD2E, ImmExtE, PCE,
           PCPlus4E, Rs1E, Rs2E, RdE, CtrlE, ValidE, StallTimeout, StallCycles, FlushCount
  );

  modport slave (
    input  StallD, FlushD, FlushE, InstrF, PCF, PCPlus4F, RD1D, RD2D, ImmExtD, CtrlD,
    output InstrD, PCD, PCPlus4D, ValidD, Rs1D, Rs2D, RdD, RD1E, RD2E, ImmExtE, PCE,
           PCPlus4E, Rs1E, Rs2E, RdE, CtrlE, ValidE, StallTimeout, StallCycles, FlushCount
  );
endinterface

// File: rtl/if_id_ex_pipe_regs.sv
// IF/ID and ID/EX pipeline registers with hold/flush handling and a stall watchdog.
// Optional performance counters enabled by defining PIPE_PERF_CNT_EN.
module if_id_ex_pipe_regs #(
  parameter int          CTRL_W    = 12,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          MAX_STALL = 15
) (
  input logic clk,
  input logic reset,
  if_id_ex_pipe_regs_if.slave bus
);

  logic [31:0]       r_instr_d, r_pc_d, r_pc4_d;
  logic              r_valid_d;
  logic [31:0]       r_rd1_e, r_rd2_e, r_imm_e, r_pc_e, r_pc4_e;
  logic [4:0]        r_rs1_e, r_rs2_e, r_rd_e;
  logic [CTRL_W-1:0] r_ctrl_e;
  logic              r_valid_e;
  logic [7:0]        r_wd_cnt;
  logic              r_timeout;
  logic [7:0]        w_wd_inc;
  logic [4:0]        w_rs1_d, w_rs2_d, w_rd_d;

  // Bubbles report x0 so the hazard unit never matches against them
  assign w_rs1_d  = r_instr_d[19:15] & {5{r_valid_d}};
  assign w_rs2_d  = r_instr_d[24:20] & {5{r_valid_d}};
  assign w_rd_d   = r_instr_d[11:7]  & {5{r_valid_d}};
  assign w_wd_inc = r_wd_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (reset || bus.FlushD) begin
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= 32'h0;
      r_pc4_d   <= 32'h0;
      r_valid_d <= 1'b0;
    end else if (!bus.StallD) begin
      r_instr_d <= bus.InstrF;
      r_pc_d    <= bus.PCF;
      r_pc4_d   <= bus.PCPlus4F;
      r_valid_d <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.FlushE) begin
      r_rd1_e   <= 32'h0;
      r_rd2_e   <= 32'h0;
      r_imm_e   <= 32'h0;
      r_pc_e    <= 32'h0;
      r_pc4_e   <= 32'h0;
      r_rs1_e   <= 5'h0;
      r_rs2_e   <= 5'h0;
      r_rd_e    <= 5'h0;
      r_ctrl_e  <= '0;
      r_valid_e <= 1'b0;
    end else begin
      r_rd1_e   <= bus.RD1D;
      r_rd2_e   <= bus.RD2D;
      r_imm_e   <= bus.ImmExtD;
      r_pc_e    <= r_pc_d;
      r_pc4_e   <= r_pc4_d;
      r_rs1_e   <= w_rs1_d;
      r_rs2_e   <= w_rs2_d;
      r_rd_e    <= w_rd_d;
      r_ctrl_e  <= bus.CtrlD;
      r_valid_e <= r_valid_d;
    end
  end

  // A flush during a stall neither advances nor clears the watchdog count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd_cnt  <= 8'h0;
      r_timeout <= 1'b0;
    end else if (!bus.StallD) begin
      r_wd_cnt <= 8'h0;
    end else if (!bus.FlushD && r_wd_cnt != 8'hFF) begin
      r_wd_cnt <= w_wd_inc;
      if (w_wd_inc == 8'(MAX_STALL)) r_timeout <= 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cycles, r_flush_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= 32'h0;
      r_flush_count  <= 32'h0;
    end else begin
      if (bus.StallD) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (bus.FlushD || bus.FlushE) r_flush_count <= r_flush_count + 32'd1;
    end
  end

  assign bus.StallCycles = r_stall_cycles;
  assign bus.FlushCount  = r_flush_count;
`else
  assign bus.StallCycles = 32'h0;
  assign bus.FlushCount  = 32'h0;
`endif

  assign bus.InstrD       = r_instr_d;
  assign bus.PCD          = r_pc_d;
  assign bus.PCPlus4D     = r_pc4_d;
  assign bus.ValidD       = r_valid_d;
  assign bus.Rs1D         = w_rs1_d;
  assign bus.Rs2D         = w_rs2_d;
  assign bus.RdD          = w_rd_d;
  assign bus.RD1E         = r_rd1_e;
  assign bus.RD2E         = r_rd2_e;
  assign bus.ImmExtE      = r_imm_e;
  assign bus.PCE          = r_pc_e;
  assign bus.PCPlus4E     = r_pc4_e;
  assign bus.Rs1E         = r_rs1_e;
  assign bus.Rs2E         = r_rs2_e;
  assign bus.RdE          = r_rd_e;
  assign bus.CtrlE        = r_ctrl_e;
  assign bus.ValidE       = r_valid_e;
  assign bus.StallTimeout = r_timeout;

endmodule

// File: tb/tb_if_id_ex_pipe_regs.sv
// Directed self-checking bench for if_id_ex_pipe_regs; perf-counter expectations follow PIPE_PERF_CNT_EN.
module tb_if_id_ex_pipe_regs;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  if_id_ex_pipe_regs_if #(.CTRL_W(12)) bus ();

  if_id_ex_pipe_regs #(
    .CTRL_W(12), .NOP_INSTR(32'h0000_0013), .MAX_STALL(15)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [31:0] EXP_STALLS  = 32'd3;
  localparam logic [31:0] EXP_FLUSHES = 32'd2;
`else
  localparam logic [31:0] EXP_STALLS  = 32'd0;
  localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.StallD = 0; bus.FlushD = 0; bus.FlushE = 0;
    bus.InstrF = 32'h0; bus.PCF = 32'h0; bus.PCPlus4F = 32'h0;
    bus.RD1D = 32'h0; bus.RD2D = 32'h0; bus.ImmExtD = 32'h0; bus.CtrlD = 12'h0;
    step(); step();
    chk("rst_instr_d", bus.InstrD, 32'h0000_0013);
    chk("rst_valid_d", {31'h0, bus.ValidD}, 32'h0);
    chk("rst_valid_e", {31'h0, bus.ValidE}, 32'h0);
    chk("rst_ctrl_e",  {20'h0, bus.CtrlE}, 32'h0);
    chk("rst_regs_d",  {17'h0, bus.Rs1D, bus.Rs2D, bus.RdD}, 32'h0);
    chk("rst_timeout", {31'h0, bus.StallTimeout}, 32'h0);
    chk("rst_pc_e",    bus.PCE, 32'h0);

    // add x2,x1,x2 at 0x100, no hazards
    reset = 1'b0;
    bus.InstrF = 32'h0020_8133; bus.PCF = 32'h100; bus.PCPlus4F = 32'h104;
    bus.RD1D = 32'h1111_2222; bus.RD2D = 32'h3333_4444; bus.ImmExtD = 32'hFFFF_FFF0;
    bus.CtrlD = 12'hABC;
    step();
    chk("ld_instr_d", bus.InstrD, 32'h0020_8133);
    chk("ld_pc_d",    bus.PCD, 32'h100);
    chk("ld_pc4_d",   bus.PCPlus4D, 32'h104);
    chk("ld_valid_d", {31'h0, bus.ValidD}, 32'h1);
    chk("ld_rs1_d",   {27'h0, bus.Rs1D}, 32'd1);
    chk("ld_rs2_d",   {27'h0, bus.Rs2D}, 32'd2);
    chk("ld_rd_d",    {27'h0, bus.RdD}, 32'd2);
    chk("ld_valid_e_lag", {31'h0, bus.ValidE}, 32'h0);
    step();
    chk("ex_pc_e",    bus.PCE, 32'h100);
    chk("ex_pc4_e",   bus.PCPlus4E, 32'h104);
    chk("ex_rd_e",    {27'h0, bus.RdE}, 32'd2);
    chk("ex_rs1_e",   {27'h0, bus.Rs1E}, 32'd1);
    chk("ex_valid_e", {31'h0, bus.ValidE}, 32'h1);
    chk("ex_ctrl_e",  {20'h0, bus.CtrlE}, 32'hABC);
    chk("ex_rd1_e",   bus.RD1E, 32'h1111_2222);
    chk("ex_imm_e",   bus.ImmExtE, 32'hFFFF_FFF0);

    // load-use: hold IF/ID, bubble ID/EX; next fetch is add x1,x2,x3 at 0x108
    bus.InstrF = 32'h0031_00B3; bus.PCF = 32'h108; bus.PCPlus4F = 32'h10C;
    bus.StallD = 1; bus.FlushE = 1;
    step();
    chk("lu_instr_d_hold", bus.InstrD, 32'h0020_8133);
    chk("lu_pc_d_hold",    bus.PCD, 32'h100);
    chk("lu_valid_e",      {31'h0, bus.ValidE}, 32'h0);
    chk("lu_ctrl_e",       {20'h0, bus.CtrlE}, 32'h0);
    chk("lu_rd_e",         {27'h0, bus.RdE}, 32'h0);
    bus.StallD = 0; bus.FlushE = 0;
    step();
    chk("lu2_rd_e",    {27'h0, bus.RdE}, 32'd2);
    chk("lu2_pc_e",    bus.PCE, 32'h100);
    chk("lu2_valid_e", {31'h0, bus.ValidE}, 32'h1);
    chk("lu2_instr_d", bus.InstrD, 32'h0031_00B3);

    // flush beats stall
    bus.FlushD = 1; bus.StallD = 1;
    step();
    chk("fs_instr_d", bus.InstrD, 32'h0000_0013);
    chk("fs_valid_d", {31'h0, bus.ValidD}, 32'h0);
    chk("fs_rd_d",    {27'h0, bus.RdD}, 32'h0);
    chk("fs_pc_d",    bus.PCD, 32'h0);
    chk("fs_rd_e",    {27'h0, bus.RdE}, 32'd1);
    chk("fs_timeout", {31'h0, bus.StallTimeout}, 32'h0);

    // watchdog: 14 stalls stay quiet, the 15th fires, stays sticky
    bus.FlushD = 0;
    for (int i = 0; i < 14; i++) step();
    chk("wd_14_quiet", {31'h0, bus.StallTimeout}, 32'h0);
    chk("wd_hold_instr", bus.InstrD, 32'h0000_0013);
    step();
    chk("wd_15_fire", {31'h0, bus.StallTimeout}, 32'h1);
    bus.StallD = 0;
    step(); step();
    chk("wd_sticky", {31'h0, bus.StallTimeout}, 32'h1);
    chk("wd_reload_instr", bus.InstrD, 32'h0031_00B3);
    reset = 1'b1;
    step(); step();
    chk("wd_rst_clear", {31'h0, bus.StallTimeout}, 32'h0);
    reset = 1'b0;

    // watchdog restarts after a stall gap
    bus.StallD = 1;
    for (int i = 0; i < 10; i++) step();
    bus.StallD = 0;
    step();
    bus.StallD = 1;
    for (int i = 0; i < 10; i++) step();
    bus.StallD = 0;
    step();
    chk("wd_gap_clear", {31'h0, bus.StallTimeout}, 32'h0);

    // perf counters from a clean reset
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("pc_rst_stalls",  bus.StallCycles, 32'h0);
    chk("pc_rst_flushes", bus.FlushCount, 32'h0);
    bus.StallD = 1;
    step(); step(); step();
    bus.StallD = 0; bus.FlushD = 1; bus.FlushE = 1;
    step(); step();
    bus.FlushD = 0; bus.FlushE = 0;
    step();
    chk("pc_stalls",  bus.StallCycles, EXP_STALLS);
    chk("pc_flushes", bus.FlushCount, EXP_FLUSHES);
    chk("pc_valid_e_after", {31'h0, bus.ValidE}, 32'h0);
    chk("pc_valid_d_after", {31'h0, bus.ValidD}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_ex_pipe_regs.md
Name: if_id_ex_pipe_regs

Overview:
- Pipeline-register bank for the IF/ID and ID/EX boundaries of the RV32I 5-stage core.
- Consumes the hazard unit's StallD, FlushD and FlushE commands and applies hold, bubble and flush to the decode and execute stages.
- Exports decoded register indices back to the hazard unit, with bubbles masked so they never produce false matches.
- Includes a consecutive-stall watchdog that flags a hung pipeline.

Parameters:
- CTRL_W, 12, width of the packed decode-control bundle (RegWrite, MemWrite, ALUCtrl, WBSel, Branch, Jump, ...).
- NOP_INSTR, 32'h00000013, instruction injected on IF/ID flush or reset (addi x0,x0,0).
- MAX_STALL, 15, consecutive StallD cycles tolerated before the watchdog fires (1..255).

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  synchronous, active-high reset
- StallD  in  1  hold IF/ID contents (from hazard unit)
- FlushD  in  1  clear IF/ID to NOP (from hazard unit)
- FlushE  in  1  clear ID/EX to bubble (from hazard unit)
- InstrF  in  32  fetched instruction
- PCF  in  32  fetch PC
- PCPlus4F  in  32  fetch PC+4
- RD1D  in  32  register-file read data 1
- RD2D  in  32  register-file read data 2
- ImmExtD  in  32  extended immediate
- CtrlD  in  CTRL_W  decode control bundle
- InstrD  out  32  registered instruction
- PCD  out  32  registered PC
- PCPlus4D  out  32  registered PC+4
- ValidD  out  1  decode slot holds a real instruction
- Rs1D  out  5  InstrD[19:15], forced 0 when ValidD=0
- Rs2D  out  5  InstrD[24:20], forced 0 when ValidD=0
- RdD  out  5  InstrD[11:7], forced 0 when ValidD=0
- RD1E  out  32  registered RD1D
- RD2E  out  32  registered RD2D
- ImmExtE  out  32  registered ImmExtD
- PCE  out  32  registered PCD
- PCPlus4E  out  32  registered PCPlus4D
- Rs1E  out  5  registered Rs1D
- Rs2E  out  5  registered Rs2D
- RdE  out  5  registered RdD
- CtrlE  out  CTRL_W  registered CtrlD
- ValidE  out  1  execute slot holds a real instruction
- StallTimeout  out  1  sticky watchdog flag
- StallCycles  out  32  performance counter (optional feature)
- FlushCount  out  32  performance counter (optional feature)

Behaviour:
- Reset (synchronous, on the clock edge): InstrD=NOP_INSTR; PCD=PCPlus4D=0; ValidD=0; all E-stage outputs 0; ValidE=0; StallTimeout=0; watchdog counter=0; perf counters=0.
- IF/ID update priority per edge: reset > FlushD > StallD > load.
  - Load: InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCPlus4F, ValidD<=1.
  - FlushD: InstrD<=NOP_INSTR, PCD<=0, PCPlus4D<=0, ValidD<=0.
  - StallD: all IF/ID registers hold.
- FlushD and StallD asserted together: flush wins. The taken branch squashes the stalled instruction.
- ID/EX update priority: reset > FlushE > load. There is no E-stage stall input.
  - FlushE: all E outputs <=0, CtrlE<=0 (no RegWrite/MemWrite), ValidE<=0.
  - Load: each E register takes its D-stage value; ValidE<=ValidD.
- StallD with FlushE together (load-use): IF/ID holds and ID/EX takes a bubble. Next cycle the held instruction enters ID/EX unchanged.
- Latency: exactly one cycle per boundary; no combinational path from inputs to registered outputs.
- Rs1D, Rs2D and RdD are combinational slices of InstrD, ANDed with ValidD. They are the only combinational outputs.
- Watchdog:
  - 8-bit counter increments on each cycle with StallD=1 and FlushD=0; it saturates at 255.
  - It clears on any cycle without StallD.
  - StallTimeout sets on the edge where the counter reaches MAX_STALL and stays set until reset.
- CTRL_W bundle is opaque; this block never decodes it.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - StallCycles increments on each cycle with StallD=1.
  - FlushCount increments on each cycle with FlushD=1 or FlushE=1 (one count per cycle even if both are asserted).
  - Both are 32-bit, wrap modulo 2^32 and clear on reset.
- Undefined: both outputs tied to 32'h0 and no counter flops are synthesised; all other behaviour identical.

Test Plan:
- Reset asserted 2 cycles → InstrD=32'h00000013, ValidD=0, ValidE=0, CtrlE=0, Rs1D=Rs2D=RdD=0, StallTimeout=0.
- Stream InstrF=32'h00208133 (add x2,x1,x2) at PCF=0x100, no hazards → next edge InstrD=0x00208133, Rs1D=1, Rs2D=2, RdD=2. The edge after: PCE=0x100, RdE=2, ValidE=1.
- StallD=1 and FlushE=1 for one cycle with InstrD=0x00208133 → InstrD unchanged, ValidE=0, CtrlE=0. Next cycle (no hazard) → RdE=2, ValidE=1.
- FlushD=1 and StallD=1 in the same cycle → InstrD=NOP_INSTR, ValidD=0, RdD=0 (flush wins).
- StallD held 15 consecutive cycles with MAX_STALL=15 → StallTimeout rises at the 15th edge and stays 1 after StallD drops; only reset clears it.
- With PIPE_PERF_CNT_EN: 3 stall cycles, then 2 cycles with FlushD=FlushE=1 → StallCycles=3, FlushCount=2. Without the macro both read 0.
